// File: rtl/ifid_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module      : ifid_hazard_stage
// Description : IF/ID pipeline register with load-use hazard detection,
//               taken-branch flush and saturating stall/flush event counters.
//               ID/EX is never held; a load-use is covered by bubbling ID/EX
//               while PC and IF/ID hold.
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_hazard_stage #(
  parameter int STALL_CYCLES = 1,   // bubbles per load-use (1 = MEM->EX fwd)
  parameter int CNT_W        = 16   // event counter width
) (
  input  logic             Clk_i,
  input  logic             Rst_n_i,
  input  logic [31:0]      IF_inst_i,
  input  logic [31:0]      IF_pcplusfour_i,
  input  logic             EX_memRead_i,
  input  logic [4:0]       EX_writeReg_i,
  input  logic             EX_branchTaken_i,
  output logic [31:0]      ID_inst_o,
  output logic [31:0]      ID_pcplusfour_o,
  output logic             ID_valid_o,
  output logic             pcWrite_o,
  output logic             ID_stall_o,
  output logic             ID_bubble_o,
  output logic [CNT_W-1:0] stallCount_o,
  output logic [CNT_W-1:0] flushCount_o
);

  // Remaining-stall counter only needs to hold STALL_CYCLES-1.
  localparam int CNT_BITS = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] STALL_RELOAD = CNT_BITS'(STALL_CYCLES - 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]         inst_q, inst_d;
  logic [31:0]         pc4_q, pc4_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic                w_pc_write;
  logic                w_bubble;
  logic                w_multi_stall;
  logic [4:0]          w_rs;
  logic [4:0]          w_rt;
  logic                w_hazard;
  logic [CNT_W-1:0]    w_stall_inc;
  logic [CNT_W-1:0]    w_flush_inc;

  // A single-cycle stall never needs the STALL state: the bubble that lands
  // in EX removes the load from the comparison on the very next cycle.
  if (STALL_CYCLES > 1) begin : g_multi_stall
    assign w_multi_stall = 1'b1;
  end else begin : g_single_stall
    assign w_multi_stall = 1'b0;
  end

  assign w_rs = inst_q[25:21];
  assign w_rt = inst_q[20:16];

  assign w_hazard = valid_q & EX_memRead_i & (EX_writeReg_i != 5'd0) &
                    ((EX_writeReg_i == w_rs) | (EX_writeReg_i == w_rt));

  // Counters park at all-ones instead of wrapping.
  assign w_stall_inc = (stall_cnt_q == {CNT_W{1'b1}}) ? stall_cnt_q
                                                      : stall_cnt_q + CNT_W'(1);
  assign w_flush_inc = (flush_cnt_q == {CNT_W{1'b1}}) ? flush_cnt_q
                                                      : flush_cnt_q + CNT_W'(1);

  // Next-state and control decode: reset > flush > stall > normal.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    inst_d      = inst_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    w_pc_write  = 1'b1;
    w_bubble    = 1'b0;

    if (!Rst_n_i) begin
      // Registers clear in the sequential block; keep ID/EX fed with bubbles.
      w_pc_write = 1'b1;
      w_bubble   = 1'b1;
    end else if (EX_branchTaken_i) begin
      // Wrong-path instruction in IF/ID is squashed, any stall is abandoned.
      w_pc_write  = 1'b1;
      w_bubble    = 1'b1;
      inst_d      = 32'd0;
      pc4_d       = 32'd0;
      valid_d     = 1'b0;
      state_d     = RUN;
      cnt_d       = '0;
      flush_cnt_d = w_flush_inc;
    end else if (state_q == STALL) begin
      // Hazard already committed; just count down the remaining bubbles.
      w_pc_write  = 1'b0;
      w_bubble    = 1'b1;
      stall_cnt_d = w_stall_inc;
      if (cnt_q == CNT_BITS'(1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_BITS'(1);
      end
    end else if (w_hazard) begin
      w_pc_write  = 1'b0;
      w_bubble    = 1'b1;
      stall_cnt_d = w_stall_inc;
      if (w_multi_stall) begin
        state_d = STALL;
        cnt_d   = STALL_RELOAD;
      end
    end else begin
      inst_d  = IF_inst_i;
      pc4_d   = IF_pcplusfour_i;
      valid_d = 1'b1;
    end
  end

  // State, IF/ID payload and counters, with synchronous active-low reset.
  always_ff @(posedge Clk_i) begin
    if (!Rst_n_i) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      inst_q      <= 32'd0;
      pc4_q       <= 32'd0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inst_q      <= inst_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ID_inst_o       = inst_q;
  assign ID_pcplusfour_o = pc4_q;
  assign ID_valid_o      = valid_q;
  assign pcWrite_o       = w_pc_write;
  assign ID_stall_o      = 1'b0;
  assign ID_bubble_o     = w_bubble;
  assign stallCount_o    = stall_cnt_q;
  assign flushCount_o    = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ifid_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifid_hazard_stage
// Description : Self-checking bench for ifid_hazard_stage. Three instances
//               share one stimulus stream: u1 (1-cycle stall), u2 (2-cycle
//               stall), u3 (1-cycle stall, 4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifid_hazard_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_inst, if_pc4;
  logic        mem_rd, br;
  logic [4:0]  wr_reg;

  logic [31:0] inst0, inst1, inst2, pc0, pc1, pc2;
  logic        v0, v1, v2, pcw0, pcw1, pcw2, stl0, stl1, stl2, bub0, bub1, bub2;
  logic [15:0] sc0, sc1, fc0, fc1;
  logic [3:0]  sc2, fc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifid_hazard_stage #(.STALL_CYCLES(1), .CNT_W(16)) u1 (
    .Clk_i(clk), .Rst_n_i(rst_n), .IF_inst_i(if_inst), .IF_pcplusfour_i(if_pc4),
    .EX_memRead_i(mem_rd), .EX_writeReg_i(wr_reg), .EX_branchTaken_i(br),
    .ID_inst_o(inst0), .ID_pcplusfour_o(pc0), .ID_valid_o(v0), .pcWrite_o(pcw0),
    .ID_stall_o(stl0), .ID_bubble_o(bub0), .stallCount_o(sc0), .flushCount_o(fc0));

  ifid_hazard_stage #(.STALL_CYCLES(2), .CNT_W(16)) u2 (
    .Clk_i(clk), .Rst_n_i(rst_n), .IF_inst_i(if_inst), .IF_pcplusfour_i(if_pc4),
    .EX_memRead_i(mem_rd), .EX_writeReg_i(wr_reg), .EX_branchTaken_i(br),
    .ID_inst_o(inst1), .ID_pcplusfour_o(pc1), .ID_valid_o(v1), .pcWrite_o(pcw1),
    .ID_stall_o(stl1), .ID_bubble_o(bub1), .stallCount_o(sc1), .flushCount_o(fc1));

  ifid_hazard_stage #(.STALL_CYCLES(1), .CNT_W(4)) u3 (
    .Clk_i(clk), .Rst_n_i(rst_n), .IF_inst_i(if_inst), .IF_pcplusfour_i(if_pc4),
    .EX_memRead_i(mem_rd), .EX_writeReg_i(wr_reg), .EX_branchTaken_i(br),
    .ID_inst_o(inst2), .ID_pcplusfour_o(pc2), .ID_valid_o(v2), .pcWrite_o(pcw2),
    .ID_stall_o(stl2), .ID_bubble_o(bub2), .stallCount_o(sc2), .flushCount_o(fc2));

  // ---------------- reference model (remaining-bubble bookkeeping) ----------
  int          STL [3]  = '{1, 2, 1};
  int          MAXC [3] = '{65535, 65535, 15};
  bit          m_v   [3];
  logic [31:0] m_inst[3];
  logic [31:0] m_pc  [3];
  int          m_rem [3];
  int          m_sc  [3];
  int          m_fc  [3];

  function automatic bit m_hazard(int k);
    logic [31:0] w;
    int rs, rt;
    w  = m_inst[k];
    rs = int'(w[25:21]);
    rt = int'(w[20:16]);
    return m_v[k] && mem_rd && (wr_reg != 5'd0) &&
           (int'(wr_reg) == rs || int'(wr_reg) == rt);
  endfunction

  function automatic bit m_stalling(int k);
    return rst_n && !br && (m_rem[k] > 0 || m_hazard(k));
  endfunction

  task automatic m_step(int k);
    if (!rst_n) begin
      m_v[k] = 0; m_inst[k] = 0; m_pc[k] = 0; m_rem[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end else if (br) begin
      m_v[k] = 0; m_inst[k] = 0; m_pc[k] = 0; m_rem[k] = 0;
      m_fc[k] = (m_fc[k] + 1 > MAXC[k]) ? MAXC[k] : m_fc[k] + 1;
    end else if (m_rem[k] > 0 || m_hazard(k)) begin
      m_rem[k] = (m_rem[k] > 0) ? m_rem[k] - 1 : STL[k] - 1;
      m_sc[k]  = (m_sc[k] + 1 > MAXC[k]) ? MAXC[k] : m_sc[k] + 1;
    end else begin
      m_v[k] = 1; m_inst[k] = if_inst; m_pc[k] = if_pc4;
    end
  endtask

  // ---------------- DUT access and checking --------------------------------
  task automatic get_out(input int k, output bit pcw, output bit bub, output bit stl,
                         output bit v, output logic [31:0] inst, output logic [31:0] pc,
                         output int sc, output int fc);
    case (k)
      0: begin pcw = pcw0; bub = bub0; stl = stl0; v = v0; inst = inst0; pc = pc0;
               sc = int'(sc0); fc = int'(fc0); end
      1: begin pcw = pcw1; bub = bub1; stl = stl1; v = v1; inst = inst1; pc = pc1;
               sc = int'(sc1); fc = int'(fc1); end
      default: begin pcw = pcw2; bub = bub2; stl = stl2; v = v2; inst = inst2; pc = pc2;
               sc = int'(sc2); fc = int'(fc2); end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_comb_model(int k);
    bit pcw, bub, stl, v; logic [31:0] inst, pc; int sc, fc;
    get_out(k, pcw, bub, stl, v, inst, pc, sc, fc);
    chk($sformatf("u%0d pcWrite", k + 1), 32'(pcw), 32'(!m_stalling(k)));
    chk($sformatf("u%0d ID_bubble", k + 1), 32'(bub), 32'(!rst_n || br || m_stalling(k)));
    chk($sformatf("u%0d ID_stall", k + 1), 32'(stl), 32'd0);
  endtask

  task automatic chk_regs_model(int k);
    bit pcw, bub, stl, v; logic [31:0] inst, pc; int sc, fc;
    get_out(k, pcw, bub, stl, v, inst, pc, sc, fc);
    chk($sformatf("u%0d ID_valid", k + 1), 32'(v), 32'(m_v[k]));
    chk($sformatf("u%0d ID_inst", k + 1), inst, m_inst[k]);
    chk($sformatf("u%0d ID_pc4", k + 1), pc, m_pc[k]);
    chk($sformatf("u%0d stallCount", k + 1), 32'(sc), 32'(m_sc[k]));
    chk($sformatf("u%0d flushCount", k + 1), 32'(fc), 32'(m_fc[k]));
  endtask

  logic [31:0] pc_ctr = 32'h0000_0400;

  task automatic drv(input bit r, input logic [31:0] inst, input bit mr,
                     input logic [4:0] wr, input bit b);
    rst_n = r; if_inst = inst; mem_rd = mr; wr_reg = wr; br = b;
    pc_ctr = pc_ctr + 32'd4;
    if_pc4 = pc_ctr;
  endtask

  // Called at negedge after drv(); returns at the following negedge.
  task automatic cyc(input bit cmp);
    #1;
    if (cmp) for (int k = 0; k < 3; k++) chk_comb_model(k);
    @(posedge clk);
    for (int k = 0; k < 3; k++) m_step(k);
    #1;
    if (cmp) for (int k = 0; k < 3; k++) chk_regs_model(k);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drv(0, 32'h0, 0, 5'd0, 0); cyc(1);
    drv(0, 32'h0, 0, 5'd0, 0); cyc(1);
  endtask

  // ---------------- directed table for u1 (STALL_CYCLES = 1) ---------------
  typedef struct {
    bit          rst_n;
    logic [31:0] inst;
    bit          mr;
    logic [4:0]  wr;
    bit          br;
    bit          pcw;   // expected before the edge
    bit          bub;
    bit          v;     // expected after the edge
    logic [31:0] id;
    int          sc;
    int          fc;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b0, 32'h0000_0020, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 0, 0};
    tbl[1] = '{1'b0, 32'h0000_0020, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 0, 0};
    tbl[2] = '{1'b1, 32'h0000_0020, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 0, 0};
    tbl[3] = '{1'b1, 32'h0022_1820, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0022_1820, 0, 0};
    tbl[4] = '{1'b1, 32'h1111_1111, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0022_1820, 1, 0};
    tbl[5] = '{1'b1, 32'h1111_1111, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 1, 0};
    tbl[6] = '{1'b1, 32'h0022_1820, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0022_1820, 1, 0};
    tbl[7] = '{1'b1, 32'h3333_3333, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0022_1820, 2, 0};
    tbl[8] = '{1'b1, 32'h3333_3333, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 2, 1};
    tbl[9] = '{1'b1, 32'h0022_1820, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0022_1820, 2, 1};
  end

  // ---------------- main sequence ------------------------------------------
  initial begin
    drv(0, 32'h0, 0, 5'd0, 0);
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 0; m_inst[k] = 0; m_pc[k] = 0; m_rem[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
    @(negedge clk);
    // Settle one reset cycle before any model comparison.
    cyc(0);

    // Table: reset, straight-line, load-use via rs and rt, EX_writeReg=0, flush.
    for (int i = 0; i < 10; i++) begin
      drv(tbl[i].rst_n, tbl[i].inst, tbl[i].mr, tbl[i].wr, tbl[i].br);
      #1;
      chk($sformatf("tbl%0d pcWrite", i), 32'(pcw0), 32'(tbl[i].pcw));
      chk($sformatf("tbl%0d ID_bubble", i), 32'(bub0), 32'(tbl[i].bub));
      cyc(1);
      chk($sformatf("tbl%0d ID_valid", i), 32'(v0), 32'(tbl[i].v));
      chk($sformatf("tbl%0d ID_inst", i), inst0, tbl[i].id);
      chk($sformatf("tbl%0d stallCount", i), 32'(sc0), 32'(tbl[i].sc));
      chk($sformatf("tbl%0d flushCount", i), 32'(fc0), 32'(tbl[i].fc));
    end

    // Two-cycle load-use on u2, then EX_writeReg=0 does not stall.
    do_reset();
    drv(1, 32'h0022_1820, 0, 5'd0, 0); cyc(1);
    drv(1, 32'h0000_0020, 1, 5'd1, 0); #1;
    chk("ls2 c1 pcWrite", 32'(pcw1), 32'd0); chk("ls2 c1 bubble", 32'(bub1), 32'd1);
    cyc(1);
    chk("ls2 c1 hold", inst1, 32'h0022_1820);
    drv(1, 32'h0000_0020, 0, 5'd0, 0); #1;
    chk("ls2 c2 pcWrite", 32'(pcw1), 32'd0); chk("ls2 c2 bubble", 32'(bub1), 32'd1);
    cyc(1);
    chk("ls2 c2 hold", inst1, 32'h0022_1820);
    chk("ls2 stallCount", 32'(sc1), 32'd2);
    drv(1, 32'h0000_0020, 0, 5'd0, 0); #1;
    chk("ls2 resume pcWrite", 32'(pcw1), 32'd1); chk("ls2 resume bubble", 32'(bub1), 32'd0);
    cyc(1);
    chk("ls2 resume inst", inst1, 32'h0000_0020);
    drv(1, 32'h0000_0020, 1, 5'd0, 0); #1;
    chk("ls2 wr0 pcWrite", 32'(pcw1), 32'd1);
    cyc(1);

    // Branch in the second stall cycle of u2.
    do_reset();
    drv(1, 32'h0022_1820, 0, 5'd0, 0); cyc(1);
    drv(1, 32'h0000_0020, 1, 5'd1, 0); cyc(1);
    drv(1, 32'h0000_0020, 0, 5'd0, 1); #1;
    chk("brstall pcWrite", 32'(pcw1), 32'd1); chk("brstall bubble", 32'(bub1), 32'd1);
    cyc(1);
    chk("brstall ID_valid", 32'(v1), 32'd0);
    chk("brstall flushCount", 32'(fc1), 32'd1);
    chk("brstall stallCount", 32'(sc1), 32'd1);
    drv(1, 32'h0000_0020, 1, 5'd1, 0); #1;
    chk("brstall RUN pcWrite", 32'(pcw1), 32'd1); chk("brstall RUN bubble", 32'(bub1), 32'd0);
    cyc(1);

    // Reset asserted mid-stall on u2.
    do_reset();
    drv(1, 32'h0022_1820, 0, 5'd0, 0); cyc(1);
    drv(1, 32'h0000_0020, 1, 5'd1, 0); cyc(1);
    drv(0, 32'h0000_0020, 0, 5'd0, 0); #1;
    chk("rststall pcWrite", 32'(pcw1), 32'd1); chk("rststall bubble", 32'(bub1), 32'd1);
    cyc(1);
    chk("rststall ID_valid", 32'(v1), 32'd0);
    chk("rststall stallCount", 32'(sc1), 32'd0);
    drv(1, 32'h0000_0020, 0, 5'd0, 0); #1;
    chk("rststall no residual", 32'(pcw1), 32'd1);
    cyc(1);
    chk("rststall reload", inst1, 32'h0000_0020);

    // Stall counter saturation on the 4-bit instance: persistent hazard.
    do_reset();
    drv(1, 32'h0022_1820, 0, 5'd0, 0); cyc(1);
    for (int i = 0; i < 20; i++) begin
      drv(1, 32'h0000_0020, 1, 5'd1, 0); cyc(1);
    end
    chk("sat stall u3", 32'(sc2), 32'h0000_000F);
    chk("sat stall u1", 32'(sc0), 32'd20);

    // Flush counter saturation at 16 bits.
    do_reset();
    for (int i = 0; i < 65534; i++) begin
      drv(1, 32'h0000_0020, 0, 5'd0, 1); cyc(0);
    end
    chk("sat flush FFFE", 32'(fc0), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'h0000_0020, 0, 5'd0, 1); cyc(0);
    end
    chk("sat flush FFFF", 32'(fc0), 32'h0000_FFFF);
    chk("sat flush u3", 32'(fc2), 32'h0000_000F);
    chk("sat flush model", 32'(fc1), 32'(m_fc[1]));

    // Randomised traffic with register fields confined to r0..r3.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ri;
      ri = $urandom;
      ri[25:21] = 5'($urandom_range(0, 3));
      ri[20:16] = 5'($urandom_range(0, 3));
      drv(($urandom_range(0, 99) != 0), ri, 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
